pipeline_flush_controller: RTL and testbench

PIPELINE_FLUSH_CONTROLLER -- requirements
Module: pipeline_flush_controller

---
 rtl/pipeline_flush_controller.sv | 123 ++++++++++++
 tb/tb_pipeline_flush_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flush_controller.sv
// Pipeline flush/stall controller: arbitrates cache stalls, load-use bubbles
// and branch redirects, holding a redirect that arrives during a cache miss
// until the pipeline unfreezes. Also keeps saturating event statistics.
module pipeline_flush_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cache_stall,
    input  logic             load_use_hazard,
    input  logic             branch_redo,
    input  logic [XLEN-1:0]  branch_target_IF,
    input  logic             stat_clear,
    output logic             pc_write_en,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] redo_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       ctrl_state
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALLED = 2'b01,
        PENDING = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pend_target;
    logic              load_pend;

    assign ctrl_state = state;

    // State register and the redirect address held across a cache miss
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            state <= state_nxt;
            if (load_pend)
                pend_target <= branch_target_IF;
        end
    end

    // Next-state and zero-latency pipeline control outputs
    always_comb begin
        state_nxt       = state;
        load_pend       = 1'b0;
        pc_write_en     = 1'b1;
        if_id_en        = 1'b1;
        pc_redirect     = 1'b0;
        redirect_target = branch_target_IF;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        case (state)
            RUN: begin
                if (cache_stall) begin
                    // Freeze; a redirect seen now must survive the miss
                    pc_write_en = 1'b0;
                    if_id_en    = 1'b0;
                    if (branch_redo) begin
                        load_pend = 1'b1;
                        state_nxt = PENDING;
                    end else begin
                        state_nxt = STALLED;
                    end
                end else if (load_use_hazard) begin
                    // ID operands are not valid yet, so any redo is bogus
                    pc_write_en = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (branch_redo) begin
                    pc_redirect = 1'b1;
                    if_id_flush = 1'b1;
                end
            end
            STALLED: begin
                pc_write_en = 1'b0;
                if_id_en    = 1'b0;
                if (branch_redo) begin
                    load_pend = 1'b1;
                    state_nxt = PENDING;
                end else if (!cache_stall) begin
                    state_nxt = RUN;
                end
            end
            PENDING: begin
                if (cache_stall) begin
                    pc_write_en = 1'b0;
                    if_id_en    = 1'b0;
                end else begin
                    pc_redirect     = 1'b1;
                    redirect_target = pend_target;
                    if_id_flush     = 1'b1;
                    state_nxt       = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Saturating statistics; clear wins over any increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redo_count  <= '0;
            stall_count <= '0;
        end else if (stat_clear) begin
            redo_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pc_redirect && !(&redo_count))
                redo_count <= redo_count + CNT_W'(1);
            if (cache_stall && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_flush_controller.sv
// Directed bench for pipeline_flush_controller: a vector table walked
// cycle by cycle plus hand sequences for saturation and mid-PENDING reset.
module tb_pipeline_flush_controller;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    // control bundle {pc_write_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush}
    localparam logic [4:0] NORM  = 5'b10100;
    localparam logic [4:0] REDIR = 5'b11110;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] LUH   = 5'b00001;
    localparam logic [1:0] S_RUN = 2'b00, S_STL = 2'b01, S_PEN = 2'b10;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cache_stall, load_use_hazard, branch_redo, stat_clear;
    logic [XLEN-1:0]  branch_target_IF;
    logic             pc_write_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] redo_count, stall_count;
    logic [1:0]       ctrl_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cs, lu, br, clr;
        logic [31:0] tgt;
        logic [4:0]  e_ctl;
        logic [31:0] e_tgt;
        logic [1:0]  e_st;
        logic [15:0] e_redo, e_stall;
    } vec_t;

    vec_t vecs[$];

    pipeline_flush_controller #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cache_stall(cache_stall), .load_use_hazard(load_use_hazard),
        .branch_redo(branch_redo), .branch_target_IF(branch_target_IF),
        .stat_clear(stat_clear),
        .pc_write_en(pc_write_en), .pc_redirect(pc_redirect),
        .redirect_target(redirect_target), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .redo_count(redo_count), .stall_count(stall_count),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic cs, logic lu, logic br, logic clr, logic [31:0] tgt,
                                logic [4:0] ctl, logic [31:0] etgt, logic [1:0] st,
                                logic [15:0] redo, logic [15:0] stl);
        vec_t v;
        v.cs = cs; v.lu = lu; v.br = br; v.clr = clr; v.tgt = tgt;
        v.e_ctl = ctl; v.e_tgt = etgt; v.e_st = st; v.e_redo = redo; v.e_stall = stl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {pc_write_en, pc_redirect, if_id_en, if_id_flush, id_ex_flush};
    endfunction

    task automatic drive(input logic cs, input logic lu, input logic br,
                         input logic clr, input logic [31:0] tgt);
        cache_stall = cs; load_use_hazard = lu; branch_redo = br;
        stat_clear = clr; branch_target_IF = tgt;
    endtask

    initial begin
        // cs lu br clr tgt | ctl target | state redo stall after the edge
        vecs.push_back(mk(0,0,0,0,32'h10,  NORM, 32'h10,  S_RUN,1'd0,0));
        vecs.push_back(mk(0,0,1,0,32'h40,  REDIR,32'h40,  S_RUN,1,0));
        vecs.push_back(mk(0,1,1,0,32'h44,  LUH,  32'h44,  S_RUN,1,0));
        vecs.push_back(mk(1,1,0,0,32'h48,  FRZ,  32'h48,  S_STL,1,1));
        vecs.push_back(mk(1,0,0,0,32'h48,  FRZ,  32'h48,  S_STL,1,2));
        vecs.push_back(mk(0,0,0,0,32'h48,  FRZ,  32'h48,  S_RUN,1,2));
        vecs.push_back(mk(0,0,0,0,32'h4c,  NORM, 32'h4c,  S_RUN,1,2));
        vecs.push_back(mk(1,0,1,0,32'h80,  FRZ,  32'h80,  S_PEN,1,3));
        vecs.push_back(mk(1,0,1,0,32'h99,  FRZ,  32'h99,  S_PEN,1,4));
        vecs.push_back(mk(1,0,0,0,32'h99,  FRZ,  32'h99,  S_PEN,1,5));
        vecs.push_back(mk(0,0,1,0,32'h99,  REDIR,32'h80,  S_RUN,2,5));
        vecs.push_back(mk(0,0,0,0,32'h20,  NORM, 32'h20,  S_RUN,2,5));
        vecs.push_back(mk(1,0,0,0,32'h30,  FRZ,  32'h30,  S_STL,2,6));
        vecs.push_back(mk(1,0,1,0,32'h200, FRZ,  32'h200, S_PEN,2,7));
        vecs.push_back(mk(0,1,0,0,32'h5,   REDIR,32'h200, S_RUN,3,7));
        vecs.push_back(mk(0,0,1,1,32'h60,  REDIR,32'h60,  S_RUN,0,0));
        vecs.push_back(mk(1,0,0,0,32'h64,  FRZ,  32'h64,  S_STL,0,1));
        vecs.push_back(mk(0,0,1,0,32'h70,  FRZ,  32'h70,  S_PEN,0,1));
        vecs.push_back(mk(0,0,0,0,32'h74,  REDIR,32'h70,  S_RUN,1,1));
        vecs.push_back(mk(1,0,0,1,32'h78,  FRZ,  32'h78,  S_STL,0,0));
        vecs.push_back(mk(0,0,0,0,32'h78,  FRZ,  32'h78,  S_RUN,0,0));

        // reset state
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        #12;
        check("reset_state", ctrl_state, S_RUN);
        check("reset_redo",  redo_count, 0);
        check("reset_stall", stall_count, 0);
        check("reset_ctl",   ctl(), NORM);
        @(negedge clk);
        reset_n = 1'b1;

        // table walk: outputs mid-cycle, state/counters after the edge
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].cs, vecs[i].lu, vecs[i].br, vecs[i].clr, vecs[i].tgt);
            #2;
            check($sformatf("v%0d_ctl", i), ctl(), vecs[i].e_ctl);
            check($sformatf("v%0d_tgt", i), redirect_target, vecs[i].e_tgt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_state", i), ctrl_state, vecs[i].e_st);
            check($sformatf("v%0d_redo", i),  redo_count, vecs[i].e_redo);
            check($sformatf("v%0d_stall", i), stall_count, vecs[i].e_stall);
        end

        // reset in the middle of PENDING drops the held redirect
        @(negedge clk);
        drive(0, 0, 1, 0, 32'h8);
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h100);
        @(posedge clk); #1;
        check("pre_rst_state", ctrl_state, S_PEN);
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h100);
        #2;
        reset_n = 1'b0;
        drive(0, 0, 1, 0, 32'h55);
        #1;
        check("async_rst_state", ctrl_state, S_RUN);
        check("async_rst_redo",  redo_count, 0);
        check("async_rst_stall", stall_count, 0);
        check("rst_run_rules_ctl", ctl(), REDIR);
        check("rst_run_rules_tgt", redirect_target, 32'h55);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h104);
        reset_n = 1'b1;
        #2;
        check("post_rst_ctl", ctl(), NORM);
        check("post_rst_tgt", redirect_target, 32'h104);
        @(posedge clk); #1;
        check("post_rst_state", ctrl_state, S_RUN);
        check("post_rst_redo",  redo_count, 0);

        // stall counter saturation, then clear beating a same-cycle increment
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        check("stall_at_max", stall_count, 16'hFFFF);
        @(posedge clk); #1;
        check("stall_saturated", stall_count, 16'hFFFF);
        check("sat_state", ctrl_state, S_STL);
        @(negedge clk);
        drive(1, 0, 0, 1, 32'h0);
        @(posedge clk); #1;
        check("clear_over_stall", stall_count, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "timeout");
    end

endmodule
